out_byte_serializer: RTL and testbench
======================================

# out_byte_serializer

Downstream consumer of the dual 64-bit counter outputs (Output0/Output1). On each enabled cycle it captures the channel selected by Slt into a 4-entry FIFO, tagged with its channel. It then serializes each stored word LSB-byte-first onto an 8-bit valid/ready stream, so the wide results can leave the design through a narrow port. It sits between the counter block and the byte-wide output interface.

## Interface
Parameters:
- WIDTH, 64, captured word width (multiple of 8)
- DEPTH, 4, FIFO entries (power of two)

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately
- In0  in  WIDTH  channel-0 word (driven from Output0)
- In1  in  WIDTH  channel-1 word (driven from Output1)
- Slt  in  1  capture select: 0 = In0, 1 = In1
- En  in  1  capture request, sampled each rising edge
- Clr  in  1  synchronous flush
- Dout  out  8  current byte
- Dout_Valid  out  1  Dout holds a valid byte
- Dout_Ready  in  1  sink accepts the byte on this edge
- Dout_Last  out  1  current byte is the final byte of its word
- Dout_Chan  out  1  channel tag of the word being sent
- Level  out  3  FIFO occupancy, 0..DEPTH (excludes the word in the shift register)
- Overflow  out  1  sticky: a capture was dropped

## Operation
- Reset values: Dout=0, Dout_Valid=0, Dout_Last=0, Dout_Chan=0, Level=0, Overflow=0, FSM=IDLE, byte index=0.
- Capture: when En=1 and Clr=0, push {Slt, Slt ? In1 : In0}.
  - Push is accepted if Level<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and Overflow is set to 1. Overflow stays set until Clr or Reset.
- FSM states:
  - IDLE: Dout_Valid=0. If the FIFO is non-empty, pop into the shift register, set byte index=0, go to SEND.
  - SEND: Dout = shift[7:0], Dout_Chan = tag, Dout_Valid=1, Dout_Last = (index==WIDTH/8-1).
- Byte transfer occurs on an edge where Dout_Valid=1 and Dout_Ready=1.
  - Not last byte: shift right by 8 and increment the index.
  - Last byte and FIFO non-empty: pop the next word on the same edge and stay in SEND with no bubble.
  - Last byte and FIFO empty: go to IDLE.
- Dout_Ready=0 holds Dout, Dout_Last and Dout_Chan stable.
- Clr has priority over everything except Reset. On the next edge it empties the FIFO, aborts SEND (goes to IDLE, Dout_Valid=0), and clears Overflow. An En in the same cycle is ignored and does not set Overflow.
- Reset asserted mid-word discards the partial word; no further bytes of that word are emitted.

## Timing
- En sampled at edge N: Level=1 after N. If the FSM is IDLE, then after N+1 Level=0, Dout_Valid=1 and the first byte is visible. Minimum capture-to-first-byte latency is 2 edges.
- With Dout_Ready held at 1, a word takes WIDTH/8 = 8 consecutive cycles. Sustained throughput is 1 byte per cycle.
- Level is registered and updates on the edge of the push or pop. A simultaneous push and pop leaves Level unchanged.
- Overflow rises on the edge that drops the word.

## Structure
- Shared package `ser_pkg`: WIDTH and DEPTH defaults, BYTES = WIDTH/8, the FSM state encoding (IDLE, SEND), and the FIFO entry layout (1-bit tag + WIDTH data).
- One sub-module, `pack_fifo`: synchronous FIFO with push/pop/flush, full/empty and level outputs, same Clk/Reset.
- The serializer FSM and shift register live in the top module.

## Test plan
- Single capture: Reset release, one cycle of En=1, Slt=0, In0=64'h0807060504030201, Dout_Ready=1 → after 2 edges Dout = 01,02,…,08 on consecutive cycles, Dout_Last only on 08, Dout_Chan=0, then Dout_Valid=0.
- Back-to-back words: capture In1=64'h1111…11 then In0=64'h2222…22 (Slt=1, then 0) → 16 contiguous valid bytes with no bubble; Dout_Chan goes 1→0 at byte 9.
- Backpressure: Dout_Ready toggles 1,0,0,1,… during a word → each byte is held stable while Ready=0, no byte is skipped or duplicated, and all 8 bytes are delivered.
- Overflow: Dout_Ready=0 with 6 consecutive En=1 (values 1..6) → Level saturates at 4, Overflow=1. After Ready=1, the words delivered are 1,2,3,4,5: word 1 was popped into the shift register, which freed the slot that accepted 5. Word 6 is dropped.
- Full with simultaneous push/pop: Level=4, last byte accepted on the same edge as En=1 → the word is accepted, Level stays 4, Overflow stays 0.
- Clr and Reset: assert Clr mid-word together with En=1 → next cycle Dout_Valid=0, Level=0, Overflow=0, and the captured word is absent. Drive Reset=0 mid-word asynchronously → all outputs are at reset values before the next edge.

Source files
------------

// File: rtl/out_byte_serializer_pkg.sv
// Shared definitions for the byte serializer: default sizes, FSM encoding
// and the layout of a FIFO entry (channel tag above the captured word).
package ser_pkg;
  localparam int SER_WIDTH = 64;
  localparam int SER_DEPTH = 4;
  localparam int SER_BYTES = SER_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic                 tag;
    logic [SER_WIDTH-1:0] data;
  } ser_entry_t;
endpackage

// File: rtl/out_byte_serializer_fifo.sv
// pack_fifo: synchronous circular-buffer FIFO with flush, full/empty and
// registered occupancy. DEPTH must be a power of two (>= 2).
module pack_fifo
  import ser_pkg::*;
#(
  parameter int DW    = SER_WIDTH + 1,
  parameter int DEPTH = SER_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_en_s, rd_en_s;

  // Pointer, occupancy and storage next-state; a push into a full FIFO is
  // only taken when the head leaves on the same edge.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    mem_d   = mem_q;
    rd_en_s = pop && !empty;
    wr_en_s = push && (!full || rd_en_s);
    if (flush) begin
      rd_d    = {AW{1'b0}};
      wr_d    = {AW{1'b0}};
      level_d = {LW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (rd_en_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      level_d = level_q + LW'(wr_en_s) - LW'(rd_en_s);
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      level_q <= {LW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      mem_q   <= mem_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == {LW{1'b0}});
  assign level = level_q;
endmodule

// File: rtl/out_byte_serializer.sv
// out_byte_serializer: captures one of two wide channels into a small FIFO
// and streams each word LSB byte first over an 8-bit valid/ready port.
module out_byte_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int DEPTH = SER_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       In0,
  input  logic [WIDTH-1:0]       In1,
  input  logic                   Slt,
  input  logic                   En,
  input  logic                   Clr,
  output logic [7:0]             Dout,
  output logic                   Dout_Valid,
  input  logic                   Dout_Ready,
  output logic                   Dout_Last,
  output logic                   Dout_Chan,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow
);
  localparam int BYTES = WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tag_q, tag_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   fifo_din_s, fifo_dout_s;
  logic             fifo_full_s, fifo_empty_s;
  logic             xfer_s, pop_s, push_req_s, push_ok_s;

  assign fifo_din_s = {Slt, (Slt ? In1 : In0)};

  pack_fifo #(
    .DW   (WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk  (Clk),
    .Reset(Reset),
    .flush(Clr),
    .push (push_ok_s),
    .pop  (pop_s),
    .din  (fifo_din_s),
    .dout (fifo_dout_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .level(Level)
  );

  // Serializer next-state: load on idle or on the last byte (no bubble),
  // shift on each accepted byte, flush everything on Clr.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    xfer_s     = (state_q == ST_SEND) && Dout_Ready;
    pop_s      = !Clr && !fifo_empty_s &&
                 ((state_q == ST_IDLE) || (xfer_s && (idx_q == LAST_IDX)));
    push_req_s = En && !Clr;
    push_ok_s  = push_req_s && (!fifo_full_s || pop_s);

    if (Clr) begin
      state_d    = ST_IDLE;
      shift_d    = {WIDTH{1'b0}};
      tag_d      = 1'b0;
      idx_d      = {IW{1'b0}};
      last_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q | (push_req_s && !push_ok_s);
      if (pop_s) begin
        state_d = ST_SEND;
        shift_d = fifo_dout_s[WIDTH-1:0];
        tag_d   = fifo_dout_s[WIDTH];
        idx_d   = {IW{1'b0}};
        last_d  = (LAST_IDX == {IW{1'b0}});
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_SEND: begin
            if (xfer_s && (idx_q == LAST_IDX)) begin
              state_d = ST_IDLE;
              shift_d = {WIDTH{1'b0}};
              tag_d   = 1'b0;
              idx_d   = {IW{1'b0}};
              last_d  = 1'b0;
            end else if (xfer_s) begin
              shift_d = {8'h00, shift_q[WIDTH-1:8]};
              idx_d   = idx_q + IW'(1);
              last_d  = ((idx_q + IW'(1)) == LAST_IDX);
            end else begin
              state_d = ST_SEND;
            end
          end
          default: begin
            state_d = ST_IDLE;
            shift_d = {WIDTH{1'b0}};
            tag_d   = 1'b0;
            idx_d   = {IW{1'b0}};
            last_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= {WIDTH{1'b0}};
      tag_q      <= 1'b0;
      idx_q      <= {IW{1'b0}};
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  // Shift register is zeroed whenever the FSM idles, so Dout reads 0 there.
  assign Dout       = shift_q[7:0];
  assign Dout_Valid = (state_q == ST_SEND);
  assign Dout_Last  = last_q;
  assign Dout_Chan  = tag_q;
  assign Overflow   = overflow_q;
endmodule

// File: tb/tb_out_byte_serializer.sv
// Randomized and directed bench for out_byte_serializer against a
// queue-based reference model of the capture FIFO and byte stream.
module tb_out_byte_serializer;
  localparam int W = 64;
  localparam int D = 4;
  localparam int B = W / 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] In0, In1;
  logic         Slt, En, Clr, Dout_Ready;
  logic [7:0]   Dout;
  logic         Dout_Valid, Dout_Last, Dout_Chan, Overflow;
  logic [2:0]   Level;

  always #5 Clk = ~Clk;

  out_byte_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Reset(Reset), .In0(In0), .In1(In1), .Slt(Slt), .En(En),
    .Clr(Clr), .Dout(Dout), .Dout_Valid(Dout_Valid), .Dout_Ready(Dout_Ready),
    .Dout_Last(Dout_Last), .Dout_Chan(Dout_Chan), .Level(Level),
    .Overflow(Overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   m_fifo[$];
  logic [7:0]   m_bytes[$];
  logic         m_tag;
  logic         m_ovf;
  bit           m_send;
  logic [7:0]   rx[$];
  logic         rx_chan[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_bytes.delete();
    m_tag  = 1'b0;
    m_ovf  = 1'b0;
    m_send = 1'b0;
  endtask

  // One clock edge of the reference: inputs are stable around the edge.
  task automatic model_edge();
    bit xfer, lastb, pop, push_ok;
    logic [W:0] w;
    xfer  = m_send && Dout_Ready;
    lastb = (m_bytes.size() == 1);
    if (Clr) begin
      model_reset();
      return;
    end
    pop     = (m_fifo.size() > 0) && (!m_send || (xfer && lastb));
    push_ok = En && ((m_fifo.size() < D) || pop);
    if (xfer) void'(m_bytes.pop_front());
    if (pop) begin
      w      = m_fifo.pop_front();
      m_tag  = w[W];
      m_send = 1'b1;
      for (int b = 0; b < B; b++) m_bytes.push_back(w[8*b +: 8]);
    end else if (xfer && lastb) begin
      m_send = 1'b0;
      m_tag  = 1'b0;
    end
    if (push_ok) m_fifo.push_back({Slt, (Slt ? In1 : In0)});
    else if (En) m_ovf = 1'b1;
  endtask

  task automatic check_outputs();
    check_val("valid", 64'(Dout_Valid), 64'(m_send));
    check_val("dout",  64'(Dout),  m_send ? 64'(m_bytes[0]) : 64'd0);
    check_val("last",  64'(Dout_Last), 64'(m_send && (m_bytes.size() == 1)));
    check_val("chan",  64'(Dout_Chan), m_send ? 64'(m_tag) : 64'd0);
    check_val("level", 64'(Level), 64'(m_fifo.size()));
    check_val("ovf",   64'(Overflow), 64'(m_ovf));
  endtask

  // Called at a negedge with inputs already set for the coming edge.
  task automatic cycle();
    if (Dout_Valid && Dout_Ready) begin
      rx.push_back(Dout);
      rx_chan.push_back(Dout_Chan);
    end
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    En = 1'b0; Clr = 1'b0; Slt = 1'b0;
  endtask

  task automatic flush();
    idle_inputs();
    Clr = 1'b1;
    cycle();
    Clr = 1'b0;
    rx.delete();
    rx_chan.delete();
  endtask

  initial begin
    logic [63:0] w;
    Reset = 1'b0; In0 = '0; In1 = '0; Slt = 1'b0; En = 1'b0; Clr = 1'b0;
    Dout_Ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge Clk);
    Reset = 1'b1;

    // Single capture, Ready held high.
    Dout_Ready = 1'b1;
    In0 = 64'h0807060504030201; Slt = 1'b0; En = 1'b1;
    cycle();
    check_val("single_level1", 64'(Level), 64'd1);
    En = 1'b0;
    cycle();
    check_val("single_first", 64'(Dout), 64'h01);
    for (int i = 0; i < 10; i++) cycle();
    check_val("single_count", 64'(rx.size()), 64'd8);
    for (int i = 0; i < 8 && i < rx.size(); i++) check_val("single_byte", 64'(rx[i]), 64'(i + 1));

    // Back-to-back words on both channels.
    flush();
    Dout_Ready = 1'b1;
    In1 = {8{8'h11}}; Slt = 1'b1; En = 1'b1;
    cycle();
    In0 = {8{8'h22}}; Slt = 1'b0;
    cycle();
    En = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check_val("b2b_count", 64'(rx.size()), 64'd16);
    if (rx.size() == 16) begin
      check_val("b2b_chan7", 64'(rx_chan[7]), 64'd1);
      check_val("b2b_chan8", 64'(rx_chan[8]), 64'd0);
      check_val("b2b_byte8", 64'(rx[8]), 64'h22);
    end

    // Backpressure 1,0,0,1 pattern.
    flush();
    In0 = 64'hF1E2D3C4B5A69788; Slt = 1'b0; En = 1'b1; Dout_Ready = 1'b1;
    cycle();
    En = 1'b0;
    for (int i = 0; i < 40; i++) begin
      Dout_Ready = ((i % 4) == 0) || ((i % 4) == 3);
      cycle();
    end
    check_val("bp_count", 64'(rx.size()), 64'd8);
    w = '0;
    for (int b = 0; b < 8 && b < rx.size(); b++) w[8*b +: 8] = rx[b];
    check_val("bp_word", w, 64'hF1E2D3C4B5A69788);

    // Overflow: six captures while stalled.
    flush();
    Dout_Ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      In0 = 64'(k); Slt = 1'b0; En = 1'b1;
      cycle();
    end
    En = 1'b0;
    check_val("ovf_level", 64'(Level), 64'd4);
    check_val("ovf_flag", 64'(Overflow), 64'd1);
    Dout_Ready = 1'b1;
    for (int i = 0; i < 50; i++) cycle();
    check_val("ovf_count", 64'(rx.size()), 64'd40);
    for (int k = 0; k < 5 && rx.size() == 40; k++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = rx[8*k + b];
      check_val("ovf_word", w, 64'(k + 1));
    end

    // Full FIFO with push on the same edge as the last-byte pop.
    flush();
    Dout_Ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      In0 = 64'(k * 16); En = 1'b1;
      cycle();
    end
    En = 1'b0;
    Dout_Ready = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    check_val("full_last", 64'(Dout_Last), 64'd1);
    check_val("full_lvl4", 64'(Level), 64'd4);
    In0 = 64'hABCD; En = 1'b1;
    cycle();
    En = 1'b0;
    check_val("full_keep", 64'(Level), 64'd4);
    check_val("full_noovf", 64'(Overflow), 64'd0);

    // Clr mid-word together with En.
    Dout_Ready = 1'b1;
    cycle();
    Clr = 1'b1; En = 1'b1; In0 = 64'h5555;
    cycle();
    Clr = 1'b0; En = 1'b0;
    check_val("clr_valid", 64'(Dout_Valid), 64'd0);
    check_val("clr_level", 64'(Level), 64'd0);
    check_val("clr_ovf", 64'(Overflow), 64'd0);
    for (int i = 0; i < 4; i++) cycle();

    // Asynchronous reset mid-word.
    In0 = 64'h7766554433221100; En = 1'b1;
    cycle();
    En = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_valid", 64'(Dout_Valid), 64'd0);
    check_val("rst_dout", 64'(Dout), 64'd0);
    check_val("rst_last", 64'(Dout_Last), 64'd0);
    check_val("rst_level", 64'(Level), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      In0 = {$urandom, $urandom};
      In1 = {$urandom, $urandom};
      Slt = 1'($urandom_range(0, 1));
      En  = ($urandom_range(0, 99) < 45);
      Clr = ($urandom_range(0, 99) == 0);
      Dout_Ready = ($urandom_range(0, 99) < 70);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
